// File: rtl/led_panel_bcm_if.sv
// HUB75 scan-driver bundle: frame-store read port, panel connector pins and status strobes.
// The driver uses the master view; the frame store / panel side uses the slave view.
interface led_panel_bcm_if #(
    parameter int COLS      = 64,
    parameter int SCAN_ROWS = 16,
    parameter int BITS      = 8
);
    localparam int AW = $clog2(SCAN_ROWS);
    localparam int CW = $clog2(COLS);

    logic                selected_buffer;
    logic                actual_buffer;
    logic [AW+CW:0]      rd_addr;
    logic [3*BITS-1:0]   rd_data_hi;
    logic [3*BITS-1:0]   rd_data_lo;
    logic [1:0]          RED;
    logic [1:0]          GREEN;
    logic [1:0]          BLUE;
    logic [AW-1:0]       A;
    logic                OE_N;
    logic                LE;
    logic                CLK;
    logic                frame_start;
    logic                col_start;

    modport master (
        input  selected_buffer, rd_data_hi, rd_data_lo,
        output actual_buffer, rd_addr, RED, GREEN, BLUE, A, OE_N, LE, CLK,
               frame_start, col_start
    );

    modport slave (
        output selected_buffer, rd_data_hi, rd_data_lo,
        input  actual_buffer, rd_addr, RED, GREEN, BLUE, A, OE_N, LE, CLK,
               frame_start, col_start
    );
endinterface

// File: rtl/led_panel_bcm.sv
// HUB75 LED-matrix scan driver with binary-code modulation and frame-boundary buffer swap.
// Each plane: SHIFT (2*COLS+2 cycles), LATCH (1), DISPLAY (BASE_ON << plane).
module led_panel_bcm #(
    parameter int COLS      = 64,
    parameter int SCAN_ROWS = 16,
    parameter int BITS      = 8,
    parameter int BASE_ON   = 4
) (
    input  logic            clk,
    input  logic            rst,
    led_panel_bcm_if.master bus
);
    localparam int AW = $clog2(SCAN_ROWS);
    localparam int CW = $clog2(COLS);
    localparam int KW = CW + 2;
    localparam int PW = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int DW = BITS + $clog2(BASE_ON + 1);
    localparam logic [KW-1:0] K_LAST     = KW'(2 * COLS + 1);
    localparam logic [KW-1:0] K_CAPT_END = KW'(2 * COLS);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

    state_t        r_state;
    logic          r_armed;
    logic [KW-1:0] r_k;
    logic [CW-1:0] r_col;
    logic [AW-1:0] r_row;
    logic [PW-1:0] r_plane;
    logic [DW-1:0] r_disp;
    logic          r_actual;
    logic [1:0]    r_red, r_green, r_blue;
    logic [AW-1:0] r_a;
    logic          r_oe_n, r_le, r_clk, r_frame_start, r_col_start;

    logic          w_last_plane, w_last_row, w_wrap;
    logic [PW-1:0] w_next_plane;
    logic [AW-1:0] w_next_row;
    logic [KW-1:0] w_k_next;
    logic [DW-1:0] w_on_len;

    always_comb begin
        w_last_plane = (r_plane == PW'(BITS - 1));
        w_last_row   = (r_row == AW'(SCAN_ROWS - 1));
        w_wrap       = w_last_plane && w_last_row;
        w_next_plane = w_last_plane ? '0 : r_plane + 1'b1;
        w_next_row   = w_last_plane ? (w_last_row ? '0 : r_row + 1'b1) : r_row;
        w_k_next     = r_k + 1'b1;
        w_on_len     = (DW'(BASE_ON) << r_plane) - DW'(1);
    end

    // IDLE is held for the release edge (r_armed clear) and then exactly one more cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_armed       <= 1'b0;
            r_k           <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_plane       <= '0;
            r_disp        <= '0;
            r_actual      <= 1'b0;
            r_red         <= '0;
            r_green       <= '0;
            r_blue        <= '0;
            r_a           <= '0;
            r_oe_n        <= 1'b1;
            r_le          <= 1'b0;
            r_clk         <= 1'b0;
            r_frame_start <= 1'b0;
            r_col_start   <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_col_start   <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_armed <= 1'b1;
                    if (r_armed) begin
                        r_state       <= SHIFT;
                        r_k           <= '0;
                        r_col         <= '0;
                        r_row         <= '0;
                        r_plane       <= '0;
                        r_actual      <= bus.selected_buffer;
                        r_frame_start <= 1'b1;
                        r_col_start   <= 1'b1;
                    end
                end
                SHIFT: begin
                    // Column c is read at k=2c, valid at k=2c+1, and clocked into the panel at k=2c+3.
                    if (r_k[0] && (r_k < K_CAPT_END)) begin
                        r_red   <= {bus.rd_data_lo[2*BITS + int'(r_plane)], bus.rd_data_hi[2*BITS + int'(r_plane)]};
                        r_green <= {bus.rd_data_lo[BITS + int'(r_plane)],   bus.rd_data_hi[BITS + int'(r_plane)]};
                        r_blue  <= {bus.rd_data_lo[int'(r_plane)],          bus.rd_data_hi[int'(r_plane)]};
                    end
                    if (r_k == K_LAST) begin
                        r_state <= LATCH;
                        r_clk   <= 1'b0;
                        r_le    <= 1'b1;
                        r_a     <= r_row;
                    end else begin
                        r_k   <= w_k_next;
                        r_col <= w_k_next[CW:1];
                        r_clk <= w_k_next[0] && (w_k_next >= KW'(3));
                    end
                end
                LATCH: begin
                    r_state <= DISPLAY;
                    r_le    <= 1'b0;
                    r_oe_n  <= 1'b0;
                    r_disp  <= w_on_len;
                end
                DISPLAY: begin
                    if (r_disp == '0) begin
                        r_state     <= SHIFT;
                        r_oe_n      <= 1'b1;
                        r_k         <= '0;
                        r_col       <= '0;
                        r_plane     <= w_next_plane;
                        r_row       <= w_next_row;
                        r_col_start <= 1'b1;
                        if (w_wrap) begin
                            r_frame_start <= 1'b1;
                            r_actual      <= bus.selected_buffer;
                        end
                    end else begin
                        r_disp <= r_disp - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.actual_buffer = r_actual;
    assign bus.rd_addr       = {r_actual, r_row, r_col};
    assign bus.RED           = r_red;
    assign bus.GREEN         = r_green;
    assign bus.BLUE          = r_blue;
    assign bus.A             = r_a;
    assign bus.OE_N          = r_oe_n;
    assign bus.LE            = r_le;
    assign bus.CLK           = r_clk;
    assign bus.frame_start   = r_frame_start;
    assign bus.col_start     = r_col_start;
endmodule

// File: tb/tb_led_panel_bcm.sv
// Directed bench for led_panel_bcm: default 64x16x8-bit geometry plus a tiny 8x2x1-bit instance.
module tb_led_panel_bcm;
    logic clk = 1'b0;
    logic rst_b;
    logic rst_s;
    always #5 clk = ~clk;

    led_panel_bcm_if #(.COLS(64), .SCAN_ROWS(16), .BITS(8)) bb ();
    led_panel_bcm_if #(.COLS(8),  .SCAN_ROWS(2),  .BITS(1)) sb ();

    led_panel_bcm #(.COLS(64), .SCAN_ROWS(16), .BITS(8), .BASE_ON(4)) u_big (
        .clk(clk), .rst(rst_b), .bus(bb));
    led_panel_bcm #(.COLS(8), .SCAN_ROWS(2), .BITS(1), .BASE_ON(1)) u_small (
        .clk(clk), .rst(rst_s), .bus(sb));

    // Frame-store models: one-cycle read latency.
    logic [23:0] mem_hi, mem_lo;
    logic        mem_colmode;
    always @(posedge clk) begin
        if (mem_colmode) begin
            bb.rd_data_hi <= {2'b00, bb.rd_addr[5:0], 16'h0000};
            bb.rd_data_lo <= {16'h0000, 2'b00, bb.rd_addr[5:0]};
        end else begin
            bb.rd_data_hi <= mem_hi;
            bb.rd_data_lo <= mem_lo;
        end
        sb.rd_data_hi <= {sb.rd_addr[0], 1'b0, 1'b1};
        sb.rd_data_lo <= 3'b010;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Phase bookkeeping for the big instance, derived from the strobes alone.
    int big_cyc = 0;
    int phase_in_frame = -1;
    int fs_cnt = 0;
    int fs_t[4];
    int cs_frame0 = -1;
    always @(negedge clk) begin
        big_cyc++;
        if (bb.col_start) begin
            if (bb.frame_start) begin
                if (fs_cnt < 4) fs_t[fs_cnt] = big_cyc;
                if (fs_cnt == 1) cs_frame0 = phase_in_frame + 1;
                fs_cnt++;
                phase_in_frame = 0;
            end else begin
                phase_in_frame++;
            end
        end
    end

    task automatic seek_plane(input int p, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            step();
            if (bb.col_start && ((phase_in_frame % 8) == p)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called in cycle k=0 of a SHIFT phase; walks to the LATCH cycle.
    task automatic scan_phase(input logic [1:0] er, input logic [1:0] eg, input logic [1:0] eb,
                              input bit colmode, input int p,
                              output int rises, output int bad, output int first_k, output int le_k);
        logic       prev;
        logic       cb;
        logic [5:0] exp;
        prev = bb.CLK;
        rises = 0; bad = 0; first_k = -1; le_k = -1;
        for (int j = 1; j <= 200; j++) begin
            step();
            if (bb.LE) begin
                le_k = j;
                break;
            end
            if (!bb.OE_N) bad++;
            if (bb.CLK && !prev) begin
                cb  = ((rises >> p) & 1) != 0;
                exp = colmode ? {1'b0, cb, 2'b00, cb, 1'b0} : {er, eg, eb};
                if ({bb.RED, bb.GREEN, bb.BLUE} !== exp) bad++;
                if (first_k < 0) first_k = j;
                rises++;
            end
            prev = bb.CLK;
        end
    endtask

    typedef struct {
        logic [23:0] hi;
        logic [23:0] lo;
        int          plane;
        logic [1:0]  red;
        logic [1:0]  green;
        logic [1:0]  blue;
    } vec_t;
    vec_t vecs[10];

    initial begin
        bit   ok;
        int   rises, bad, first_k, le_k, len, plen, row, a_seen;
        logic prev;

        vecs[0] = '{24'hFF0000, 24'h0000FF, 0, 2'b01, 2'b00, 2'b10};
        vecs[1] = '{24'hFF0000, 24'h0000FF, 7, 2'b01, 2'b00, 2'b10};
        vecs[2] = '{24'h050000, 24'h000000, 0, 2'b01, 2'b00, 2'b00};
        vecs[3] = '{24'h050000, 24'h000000, 1, 2'b00, 2'b00, 2'b00};
        vecs[4] = '{24'h050000, 24'h000000, 2, 2'b01, 2'b00, 2'b00};
        vecs[5] = '{24'h050000, 24'h000000, 3, 2'b00, 2'b00, 2'b00};
        vecs[6] = '{24'h00AA00, 24'h00AA00, 1, 2'b00, 2'b11, 2'b00};
        vecs[7] = '{24'h00AA00, 24'h00AA00, 0, 2'b00, 2'b00, 2'b00};
        vecs[8] = '{24'h000001, 24'h800000, 0, 2'b00, 2'b00, 2'b01};
        vecs[9] = '{24'h000001, 24'h800000, 7, 2'b10, 2'b00, 2'b00};

        rst_b = 1'b1; rst_s = 1'b1;
        bb.selected_buffer = 1'b0; sb.selected_buffer = 1'b0;
        mem_hi = '0; mem_lo = '0; mem_colmode = 1'b0;
        repeat (3) step();

        chk("rst_big_oe", bb.OE_N, 1);
        chk("rst_big_rest", {bb.actual_buffer, bb.rd_addr, bb.RED, bb.GREEN, bb.BLUE, bb.A,
                             bb.LE, bb.CLK, bb.frame_start, bb.col_start}, 0);
        chk("rst_small_oe", sb.OE_N, 1);
        chk("rst_small_rest", {sb.actual_buffer, sb.rd_addr, sb.RED, sb.GREEN, sb.BLUE, sb.A,
                               sb.LE, sb.CLK, sb.frame_start, sb.col_start}, 0);

        // Tiny instance: 20-cycle planes, 40-cycle frames, A alternating.
        @(negedge clk); rst_s = 1'b0;
        step(); chk("s_idle_fs", sb.frame_start, 0);
        step();
        for (int ph = 0; ph < 4; ph++) begin
            chk("s_col_start", sb.col_start, 1);
            chk("s_frame_start", sb.frame_start, (ph % 2) == 0);
            rises = 0; bad = 0; len = 0; plen = 0; a_seen = -1; prev = sb.CLK;
            for (int j = 1; j <= 40; j++) begin
                step();
                if (sb.col_start) begin
                    plen = j;
                    break;
                end
                if (sb.CLK && !prev) begin
                    if ({sb.RED, sb.GREEN, sb.BLUE} !== {1'b0, rises[0], 2'b10, 2'b01}) bad++;
                    rises++;
                end
                prev = sb.CLK;
                if (!sb.OE_N) begin
                    len++;
                    a_seen = int'(sb.A);
                end
            end
            chk("s_plane_len", plen, 20);
            chk("s_clk_rises", rises, 8);
            chk("s_rgb", bad, 0);
            chk("s_oe_len", len, 1);
            chk("s_row_a", a_seen, ph % 2);
        end

        // Default instance.
        @(negedge clk); rst_b = 1'b0;
        step(); chk("b_idle_fs", bb.frame_start, 0);
        step();
        chk("b_fs", bb.frame_start, 1);
        chk("b_cs", bb.col_start, 1);
        chk("b_buf0", {bb.actual_buffer, bb.rd_addr[10]}, 0);

        foreach (vecs[i]) begin
            mem_hi = vecs[i].hi;
            mem_lo = vecs[i].lo;
            seek_plane(vecs[i].plane, ok);
            chk("seek_plane", ok, 1);
            scan_phase(vecs[i].red, vecs[i].green, vecs[i].blue, 1'b0, vecs[i].plane,
                       rises, bad, first_k, le_k);
            chk("vec_rgb", bad, 0);
            chk("vec_clk_rises", rises, 64);
            chk("vec_first_rise_k", first_k, 3);
            chk("vec_latch_k", le_k, 130);
        end

        // Column-dependent data pins down the read latency and column order.
        mem_colmode = 1'b1;
        for (int p = 0; p < 6; p += 5) begin
            seek_plane(p, ok);
            chk("col_seek", ok, 1);
            scan_phase(2'b00, 2'b00, 2'b00, 1'b1, p, rises, bad, first_k, le_k);
            chk("col_rgb", bad, 0);
            chk("col_rises", rises, 64);
        end
        mem_colmode = 1'b0;

        // OE_N-low durations across one row.
        seek_plane(0, ok);
        chk("oe_seek", ok, 1);
        row = phase_in_frame / 8;
        for (int b = 0; b < 8; b++) begin
            len = 0; a_seen = -1;
            for (int i = 0; i < 300 && bb.OE_N; i++) step();
            a_seen = int'(bb.A);
            for (int i = 0; i < 600 && !bb.OE_N; i++) begin
                len++;
                step();
            end
            chk("oe_len", len, 4 << b);
            chk("oe_row_a", a_seen, row);
        end

        // Buffer request toggled mid-frame; the value at the boundary wins.
        step(); bb.selected_buffer = 1'b1;
        repeat (50) step(); bb.selected_buffer = 1'b0;
        repeat (50) step(); bb.selected_buffer = 1'b1;
        bad = 0; ok = 1'b0;
        for (int i = 0; i < 40000; i++) begin
            step();
            if (bb.frame_start) begin
                ok = 1'b1;
                break;
            end
            if (bb.actual_buffer !== 1'b0 || bb.rd_addr[10] !== 1'b0) bad++;
        end
        chk("buf_wait_fs", ok, 1);
        chk("buf_held_mid_frame", bad, 0);
        chk("buf_swapped", {bb.actual_buffer, bb.rd_addr[10]}, 2'b11);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (bb.actual_buffer !== 1'b1 || bb.rd_addr[10] !== 1'b1) bad++;
        end
        chk("buf_stays", bad, 0);

        chk("frame_len", fs_t[1] - fs_t[0], 33088);
        chk("col_starts_per_frame", cs_frame0, 128);

        // Asynchronous reset in the middle of a DISPLAY phase of a non-zero row.
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            step();
            if (!bb.OE_N && bb.A != 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst_seek_display", ok, 1);
        #2 rst_b = 1'b1;
        #1;
        chk("rst_async_oe", bb.OE_N, 1);
        chk("rst_async_a", bb.A, 0);
        chk("rst_async_rest", {bb.actual_buffer, bb.rd_addr, bb.LE, bb.CLK, bb.frame_start,
                               bb.col_start}, 0);
        repeat (3) step();
        @(negedge clk); rst_b = 1'b0;
        step(); chk("rst_idle_fs", bb.frame_start, 0);
        step();
        chk("rst_restart_fs", bb.frame_start, 1);
        chk("rst_restart_addr", bb.rd_addr, 11'h400);
        len = 0;
        for (int i = 0; i < 300 && bb.OE_N; i++) step();
        a_seen = int'(bb.A);
        for (int i = 0; i < 600 && !bb.OE_N; i++) begin
            len++;
            step();
        end
        chk("rst_restart_oe_len", len, 4);
        chk("rst_restart_a", a_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
